// File: rtl/ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_master
// Description : Request/response master for a single-port RAM with a shared
//               bidirectional data bus. Performs single-word writes and
//               single or critical-word-first wrapped burst reads.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bus_master #(
    parameter int ADDRESS_SIZE  = 11,
    parameter int MEM_WORD_SIZE = 64,
    parameter int BURST_LEN     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic                     req_burst,
    input  logic [ADDRESS_SIZE-1:0]  req_addr,
    input  logic [MEM_WORD_SIZE-1:0] req_wdata,
    output logic                     resp_valid,
    output logic [MEM_WORD_SIZE-1:0] resp_rdata,
    output logic                     resp_last,
    output logic [ADDRESS_SIZE-1:0]  mem_address,
    output logic                     mem_is_reading,
    inout  wire  [MEM_WORD_SIZE-1:0] mem_data
);

    // Width of the in-block word offset used for the wrapped burst.
    localparam int                 c_OFF_W = $clog2(BURST_LEN);
    localparam logic [c_OFF_W-1:0] c_ONE   = c_OFF_W'(1);
    localparam logic [c_OFF_W-1:0] c_LAST  = c_OFF_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_ADDR = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_burst;
    logic [MEM_WORD_SIZE-1:0]   r_wdata;
    logic [c_OFF_W-1:0]         r_base_lo;   // offset of the critical word
    logic [c_OFF_W-1:0]         r_beat;      // index of the beat on the address bus
    logic                       r_cap_pend;  // RAM returns a beat's data next cycle
    logic                       r_cap_last;
    logic                       w_drive;
    logic                       w_accept;
    logic [c_OFF_W-1:0]         w_last_idx;
    logic [c_OFF_W-1:0]         w_beat_next;
    logic [c_OFF_W-1:0]         w_next_off;
    logic [ADDRESS_SIZE-1:0]    w_next_addr;

    assign w_accept    = req_valid && req_ready;
    assign w_last_idx  = r_burst ? c_LAST : '0;
    assign w_beat_next = r_beat + c_ONE;
    // Offset wraps modulo BURST_LEN by truncation, so the block is never left.
    assign w_next_off  = r_base_lo + w_beat_next;

    generate
        if (c_OFF_W < ADDRESS_SIZE) begin : g_block_hi
            assign w_next_addr = {mem_address[ADDRESS_SIZE-1:c_OFF_W], w_next_off};
        end else begin : g_block_full
            assign w_next_addr = w_next_off;
        end
    endgenerate

    // Only the master drives the bus, and only while the RAM is told to write.
    assign mem_data = w_drive ? r_wdata : 'z;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_next   = r_state;
        req_ready      = 1'b0;
        mem_is_reading = 1'b1;
        w_drive        = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = req_write ? WRITE : RD_ADDR;
                end
            end
            WRITE: begin
                mem_is_reading = 1'b0;
                w_drive        = 1'b1;
                w_state_next   = IDLE;
            end
            RD_ADDR: begin
                if (r_beat == w_last_idx) begin
                    w_state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request latch, burst address generation and response pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst     <= 1'b0;
            r_wdata     <= '0;
            r_base_lo   <= '0;
            r_beat      <= '0;
            r_cap_pend  <= 1'b0;
            r_cap_last  <= 1'b0;
            mem_address <= '0;
            resp_valid  <= 1'b0;
            resp_last   <= 1'b0;
            resp_rdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            r_cap_pend <= 1'b0;
            r_cap_last <= 1'b0;

            if (w_accept) begin
                r_burst     <= req_burst;
                r_wdata     <= req_wdata;
                r_base_lo   <= req_addr[c_OFF_W-1:0];
                r_beat      <= '0;
                mem_address <= req_addr;
            end

            if (r_state == RD_ADDR) begin
                r_cap_pend <= 1'b1;
                r_cap_last <= (r_beat == w_last_idx);
                if (r_beat != w_last_idx) begin
                    r_beat      <= w_beat_next;
                    mem_address <= w_next_addr;
                end
            end

            if (r_state == WRITE) begin
                resp_valid <= 1'b1;
                resp_last  <= 1'b1;
                resp_rdata <= '0;
            end

            // The RAM output for the beat issued two cycles ago is on the bus now.
            if (r_cap_pend) begin
                resp_valid <= 1'b1;
                resp_last  <= r_cap_last;
                resp_rdata <= mem_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_bus_master
// Description : Self-checking bench for ram_bus_master with a synchronous RAM
//               on the shared bus and a cycle-indexed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bus_master;

    localparam int AW = 11;
    localparam int DW = 64;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic          req_burst = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_last;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] mem_address;
    logic          mem_is_reading;
    wire  [DW-1:0] mem_data;

    ram_bus_master #(
        .ADDRESS_SIZE (AW),
        .MEM_WORD_SIZE(DW),
        .BURST_LEN    (BL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_burst     (req_burst),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_last     (resp_last),
        .mem_address   (mem_address),
        .mem_is_reading(mem_is_reading),
        .mem_data      (mem_data)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: writes whenever isReading is low, registered read data
    // driven onto the bus while isReading is high. ovr replaces the bus value.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q = '0;
    logic          ovr = 1'b0;
    logic [DW-1:0] ovr_val = '0;
    wire  [DW-1:0] drv_val = ovr ? ovr_val : ram_q;
    assign mem_data = mem_is_reading ? drv_val : 'z;

    always @(posedge clk) begin
        if (!mem_is_reading) ram[mem_address] <= mem_data;
        ram_q <= ram[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expectations keyed by cycle number.
    logic [DW-1:0] mdl_mem [int];
    bit            exp_v [int];
    logic [DW-1:0] exp_d [int];
    bit            exp_l [int];
    logic [AW-1:0] exp_a [int];
    logic [DW-1:0] exp_w [int];
    int            free_cyc = 0;
    logic [AW-1:0] mdl_addr = '0;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic monitor();
        int c = cyc;
        check("req_ready", 64'(req_ready), 64'(c >= free_cyc));
        if (exp_a.exists(c)) mdl_addr = exp_a[c];
        check("mem_address", 64'(mem_address), 64'(mdl_addr));
        if (exp_w.exists(c)) begin
            check("is_reading_wr", 64'(mem_is_reading), 64'(0));
            check("bus_wdata", mem_data, exp_w[c]);
        end else begin
            check("is_reading", 64'(mem_is_reading), 64'(1));
            check("bus_owner", mem_data, drv_val);
        end
        if (exp_v.exists(c)) begin
            check("resp_valid", 64'(resp_valid), 64'(1));
            check("resp_rdata", resp_rdata, exp_d[c]);
            check("resp_last", 64'(resp_last), 64'(exp_l[c]));
        end else begin
            check("resp_valid_idle", 64'(resp_valid), 64'(0));
            check("resp_last_idle", 64'(resp_last), 64'(0));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    // Accepted request in cycle n: record every consequence by cycle number.
    task automatic model_accept(input int n, input bit w, input bit b,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        int ia = int'(a);
        if (w) begin
            exp_a[n+1] = a;
            exp_w[n+1] = d;
            mdl_mem[ia] = d;
            exp_v[n+2] = 1'b1;
            exp_d[n+2] = '0;
            exp_l[n+2] = 1'b1;
            free_cyc = n + 2;
        end else begin
            int nb  = b ? BL : 1;
            int blk = ia - (ia % BL);
            for (int i = 0; i < nb; i++) begin
                int ai = blk + ((ia + i) % BL);
                exp_a[n+1+i] = AW'(ai);
                exp_v[n+3+i] = 1'b1;
                exp_d[n+3+i] = mdl_mem.exists(ai) ? mdl_mem[ai] : '0;
                exp_l[n+3+i] = (i == nb - 1);
            end
            free_cyc = n + nb + 2;
        end
    endtask

    task automatic model_reset();
        exp_v.delete();
        exp_d.delete();
        exp_l.delete();
        exp_a.delete();
        exp_w.delete();
        free_cyc = 0;
        mdl_addr = '0;
    endtask

    // Present a request and hold it until the model says it is accepted.
    task automatic req(input bit w, input bit b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waited = 0;
        req_valid = 1'b1;
        req_write = w;
        req_burst = b;
        req_addr  = a;
        req_wdata = d;
        while (cyc < free_cyc && waited < 64) begin
            tick();
            waited++;
        end
        if (cyc < free_cyc) begin
            n_chk++;
            $display("FAIL accept_timeout: request at addr %0d not accepted", a);
        end else begin
            model_accept(cyc, w, b, a, d);
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_burst = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = {$urandom, $urandom};
            tick();
        end
    endtask

    function automatic logic [AW-1:0] pool_addr(input int idx);
        return (idx < 32) ? AW'(idx) : AW'(2044 + idx - 32);
    endfunction

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        idle(2);

        // Known block contents for the wrapped burst.
        for (int i = 8; i < 12; i++) req(1'b1, 1'b0, AW'(i), DW'(i));
        // Write then single read.
        req(1'b1, 1'b0, AW'(5), 64'hDEAD_BEEF);
        req(1'b0, 1'b0, AW'(5), '0);
        idle(3);
        // Fill the rest of the address pool with random words.
        for (int i = 0; i < 36; i++) begin
            if (i != 5 && (i < 8 || i > 11))
                req(1'b1, 1'b0, pool_addr(i), {$urandom, $urandom});
        end
        // Wrapped burst inside a block, then at the top of memory.
        req(1'b0, 1'b1, AW'(10), '0);
        idle(4);
        req(1'b0, 1'b1, AW'(2047), '0);
        idle(4);
        // Write held valid during a burst: accepted in the last-beat cycle.
        req(1'b0, 1'b1, AW'(10), '0);
        req(1'b1, 1'b0, AW'(20), {$urandom, $urandom});
        idle(4);

        // Reset asserted partway through the second address cycle of a burst.
        req(1'b0, 1'b1, AW'(2), '0);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_ready", 64'(req_ready), 64'(1));
        check("rst_is_reading", 64'(mem_is_reading), 64'(1));
        check("rst_address", 64'(mem_address), 64'(0));
        check("rst_valid", 64'(resp_valid), 64'(0));
        check("rst_last", 64'(resp_last), 64'(0));
        check("rst_rdata", resp_rdata, 64'(0));
        repeat (3) tick();
        reset = 1'b0;
        idle(4);

        // Random traffic over the written pool with random gaps.
        for (int t = 0; t < 80; t++) begin
            logic [AW-1:0] a = pool_addr(int'($urandom_range(0, 35)));
            if ($urandom_range(0, 2) == 0) req(1'b1, 1'b0, a, {$urandom, $urandom});
            else req(1'b0, 1'($urandom), a, '0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(6);

        // Idle with garbage on the bus: nothing may be written.
        ovr = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ovr_val = {$urandom, $urandom};
            idle(1);
        end
        ovr = 1'b0;
        idle(2);
        foreach (mdl_mem[k]) check("ram_intact", ram[k], mdl_mem[k]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ram_bus_master.md
RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 Parameter ADDRESS_SIZE, default 11, word-address width of the RAM port.
REQ-002 Parameter MEM_WORD_SIZE, default 64, data word width.
REQ-003 Parameter BURST_LEN, default 4, read-burst beat count; power of two, at least 2 and at most 2**ADDRESS_SIZE.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  a request is presented.
REQ-008 req_ready  output  1  the master accepts a request this cycle.
REQ-009 req_write  input  1  1 = single-word write, 0 = read.
REQ-010 req_burst  input  1  for reads only: 1 = BURST_LEN beats, 0 = one beat.
REQ-011 req_addr  input  ADDRESS_SIZE  word address.
REQ-012 req_wdata  input  MEM_WORD_SIZE  write data.
REQ-013 resp_valid  output  1  one-cycle pulse per read beat or write acknowledge; no backpressure.
REQ-014 resp_rdata  output  MEM_WORD_SIZE  read data; 0 on a write acknowledge.
REQ-015 resp_last  output  1  final beat of the transaction.
REQ-016 mem_address  output  ADDRESS_SIZE  to the RAM address port.
REQ-017 mem_is_reading  output  1  to the RAM isReading port.
REQ-018 mem_data  inout  MEM_WORD_SIZE  shared RAM data bus.

Function
REQ-019 A request is accepted at a rising edge where req_valid and req_ready are both 1; call the cycle ending at that edge cycle N.
REQ-020 Accepting a request latches req_write, req_burst, req_addr and req_wdata.
REQ-021 req_ready is 1 only in state IDLE.
REQ-022 FSM states are IDLE, WRITE, RD_ADDR and RD_WAIT.
REQ-023 FSM transitions:
- IDLE to WRITE on an accepted write.
- IDLE to RD_ADDR on an accepted read.
- WRITE to IDLE after one cycle.
- RD_ADDR to RD_WAIT after B cycles (B = BURST_LEN if burst, else 1).
- RD_WAIT to IDLE after one cycle.
REQ-024 mem_is_reading is 0 only in WRITE and 1 in every other state, including IDLE and reset, because the RAM writes on every edge where isReading is 0.
REQ-025 mem_data is driven with the latched write data only in WRITE; it is high-impedance in every other state.
REQ-026 Write timing: in cycle N+1, mem_address = A and mem_is_reading = 0, so the RAM writes at the edge closing N+1.
REQ-027 Write acknowledge: in cycle N+2, resp_valid = 1, resp_last = 1 and resp_rdata = 0.
REQ-028 Read addressing: in cycle N+1+i, for i = 0..B-1, mem_address = {A[high bits], (A[low log2(BURST_LEN) bits] + i) mod BURST_LEN}, a critical-word-first wrap inside the aligned block.
REQ-029 Read addressing never carries out of the aligned block, including at address 2**ADDRESS_SIZE - 1.
REQ-030 Read data capture: the master registers mem_data at the edge closing cycle N+2+i.
REQ-031 Read data return: in cycle N+3+i, resp_valid = 1 and resp_rdata = the RAM word at the beat-i address.
REQ-032 resp_last is 1 only on beat B-1 of a read.
REQ-033 The last read beat coincides with the first IDLE cycle; a new request accepted in that cycle is legal.
REQ-034 A back-to-back write after a read never drives mem_data while mem_is_reading = 1, so there is no bus contention.
REQ-035 In RD_WAIT and IDLE, mem_address holds its last value.
REQ-036 req_* inputs are ignored when req_ready = 0.

Reset
REQ-037 While reset = 1, and asynchronously on its assertion:
- state = IDLE and req_ready = 1;
- mem_is_reading = 1 and mem_data is high-impedance;
- mem_address = 0;
- resp_valid = 0, resp_last = 0, resp_rdata = 0.
REQ-038 Reset during WRITE or RD_ADDR aborts the transaction and produces no further resp_valid pulses.
REQ-039 RAM contents are not affected by reset.

Verification
REQ-040 Write then read: write addr 5 data 64'hDEAD_BEEF, then single read addr 5 -> write ack at N+2; read resp_valid at N+3 with data DEAD_BEEF and resp_last = 1.
REQ-041 Wrapped burst: preload addresses 8..11 with values 8..11, burst read addr 10 -> beats return 10, 11, 8, 9 in consecutive cycles; resp_last only on the 9.
REQ-042 Top-of-memory wrap: burst read addr 2047 -> addresses 2047, 2044, 2045, 2046 are issued; the address never reaches 0.
REQ-043 Back-to-back: a write request held valid during a burst read -> accepted in the last-beat cycle; mem_data is never driven while mem_is_reading = 1.
REQ-044 Reset mid-burst: assert reset during the second RD_ADDR cycle -> outputs reach reset values immediately; no further resp_valid; mem_is_reading = 1.
REQ-045 Idle integrity: 100 idle cycles with mem_data forced to X -> mem_is_reading stays 1 and the RAM contents are unchanged.
